// File: rtl/encod_serial_8_3.sv
// encod_serial_8_3: sequential 8-to-3 encoder.
// Accepts an 8-bit event vector and emits one 3-bit code per set bit
// (bits 0..6) over a valid/ready handshake. Each code is the one the
// downstream 3-to-8 decoder maps back to the same one-hot bit. Bit 7
// has no code and only raises a one-cycle err pulse.
module encod_serial_8_3 #(
    parameter bit PRIO_HIGH = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out,
    output logic       out_last,
    output logic       err
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [6:0] pending;
    logic [2:0] sel_idx;
    logic [6:0] sel_mask;
    logic [6:0] remaining;
    logic       accept;
    logic       xfer;

    // Index of the bit to service next: lowest set bit, or highest when
    // PRIO_HIGH is set. Returns 0 for an empty vector; callers guard that.
    function automatic logic [2:0] pick_index(input logic [6:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (PRIO_HIGH) begin
            for (int i = 0; i < 7; i++)
                if (v[i]) idx = 3'(i);
        end else begin
            for (int i = 6; i >= 0; i--)
                if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Code map matching the decoder; 110 is deliberately never produced.
    function automatic logic [2:0] code_of(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = 3'b001;
            3'd1:    c = 3'b010;
            3'd2:    c = 3'b011;
            3'd3:    c = 3'b100;
            3'd4:    c = 3'b101;
            3'd5:    c = 3'b111;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    // Code to present for a vector, or 000 when nothing is left.
    function automatic logic [2:0] next_code(input logic [6:0] v);
        return (v != 7'd0) ? code_of(pick_index(v)) : 3'b000;
    endfunction

    // True when exactly one bit is set, i.e. the code shown is the last.
    function automatic logic single_bit(input logic [6:0] v);
        return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
    endfunction

    // Handshake decode and selection of the bit currently being emitted.
    always_comb begin
        in_ready  = en && (state == IDLE);
        out_valid = en && (state == EMIT);
        accept    = in_valid && in_ready;
        xfer      = out_valid && out_ready;
        sel_idx   = pick_index(pending);
        sel_mask  = 7'd1 << sel_idx;
        remaining = pending & ~sel_mask;
    end

    // Next-state logic: leave IDLE only for a vector with codes to emit,
    // return once the final code has been taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && (in[6:0] != 7'd0)) state_next = EMIT;
            EMIT: if (xfer && out_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Pending bits and registered code/last/err, updated on accept and on
    // each transfer so the outputs always describe the bit now selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 7'd0;
            out      <= 3'b000;
            out_last <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= accept && in[7];
            if (accept) begin
                pending  <= in[6:0];
                out      <= next_code(in[6:0]);
                out_last <= single_bit(in[6:0]);
            end else if (xfer) begin
                pending  <= remaining;
                out      <= next_code(remaining);
                out_last <= single_bit(remaining);
            end
        end
    end

endmodule

// File: tb/tb_encod_serial_8_3.sv
// tb_encod_serial_8_3: directed self-checking bench for encod_serial_8_3.
// Two instances share clock, reset, enable, data and out_ready; each has
// its own in_valid so the PRIO_HIGH=1 copy stays idle until its own test.
module tb_encod_serial_8_3;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       in_valid_lo, in_ready_lo, out_valid_lo, out_last_lo, err_lo;
    logic [2:0] out_lo;
    logic       in_valid_hi, in_ready_hi, out_valid_hi, out_last_hi, err_hi;
    logic [2:0] out_hi;

    int total;
    int bad;

    encod_serial_8_3 #(.PRIO_HIGH(1'b0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(in_valid_lo), .in_ready(in_ready_lo), .in(in_vec),
        .out_valid(out_valid_lo), .out_ready(out_ready), .out(out_lo),
        .out_last(out_last_lo), .err(err_lo)
    );

    encod_serial_8_3 #(.PRIO_HIGH(1'b1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(in_valid_hi), .in_ready(in_ready_hi), .in(in_vec),
        .out_valid(out_valid_hi), .out_ready(out_ready), .out(out_hi),
        .out_last(out_last_hi), .err(err_hi)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 3-to-8 decoder with enable held high (loop-back model).
    function automatic logic [7:0] decode(input logic [2:0] c);
        case (c)
            3'b001:  return 8'b0000_0001;
            3'b010:  return 8'b0000_0010;
            3'b011:  return 8'b0000_0100;
            3'b100:  return 8'b0000_1000;
            3'b101:  return 8'b0001_0000;
            3'b111:  return 8'b0010_0000;
            3'b000:  return 8'b0100_0000;
            default: return 8'b1000_0000;
        endcase
    endfunction

    // Advance to 2 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present a vector to the low-priority instance for one edge.
    task automatic send_lo(input logic [7:0] v);
        in_vec      = v;
        in_valid_lo = 1'b1;
        tick();
        in_valid_lo = 1'b0;
        #1;
    endtask

    task automatic send_hi(input logic [7:0] v);
        in_vec      = v;
        in_valid_hi = 1'b1;
        tick();
        in_valid_hi = 1'b0;
        #1;
    endtask

    // Reset values, then an asynchronous reset in the middle of a burst.
    task automatic test_reset();
        total++; if (out_valid_lo !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid got=%b want=0", out_valid_lo); end
        total++; if (out_lo !== 3'b000) begin bad++; $display("[TB] FAIL rst_out got=%b want=000", out_lo); end
        total++; if (in_ready_lo !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_ready got=%b want=1", in_ready_lo); end
        tick();
        rst_n = 1'b1;
        tick();
        send_lo(8'b0100_0101);
        tick();
        #1;
        total++; if (out_lo !== 3'b011) begin bad++; $display("[TB] FAIL rst_pre_code got=%b want=011", out_lo); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid_lo !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_valid got=%b want=0", out_valid_lo); end
        total++; if (out_lo !== 3'b000) begin bad++; $display("[TB] FAIL rst_async_out got=%b want=000", out_lo); end
        total++; if (err_lo !== 1'b0 || out_last_lo !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_err_last got=%b%b want=00", err_lo, out_last_lo); end
        tick();
        rst_n = 1'b1;
        #1;
        total++; if (in_ready_lo !== 1'b1) begin bad++; $display("[TB] FAIL rst_release_ready got=%b want=1", in_ready_lo); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (out_valid_lo !== 1'b0) begin bad++; $display("[TB] FAIL rst_residual cyc=%0d got=%b want=0", i, out_valid_lo); end
        end
    endtask

    // Lowest-first burst with no stalls.
    task automatic test_basic();
        send_lo(8'b0100_0101);
        total++; if (out_valid_lo !== 1'b1 || out_lo !== 3'b001 || out_last_lo !== 1'b0) begin bad++; $display("[TB] FAIL basic_c0 got v=%b o=%b l=%b want v=1 o=001 l=0", out_valid_lo, out_lo, out_last_lo); end
        tick(); #1;
        total++; if (out_valid_lo !== 1'b1 || out_lo !== 3'b011 || out_last_lo !== 1'b0) begin bad++; $display("[TB] FAIL basic_c1 got v=%b o=%b l=%b want v=1 o=011 l=0", out_valid_lo, out_lo, out_last_lo); end
        tick(); #1;
        total++; if (out_valid_lo !== 1'b1 || out_lo !== 3'b000 || out_last_lo !== 1'b1) begin bad++; $display("[TB] FAIL basic_c2 got v=%b o=%b l=%b want v=1 o=000 l=1", out_valid_lo, out_lo, out_last_lo); end
        tick(); #1;
        total++; if (out_valid_lo !== 1'b0 || in_ready_lo !== 1'b1) begin bad++; $display("[TB] FAIL basic_done got v=%b r=%b want v=0 r=1", out_valid_lo, in_ready_lo); end
    endtask

    // Three stalled cycles on the second code.
    task automatic test_backpressure();
        send_lo(8'b0100_0101);
        total++; if (out_lo !== 3'b001) begin bad++; $display("[TB] FAIL bp_c0 got=%b want=001", out_lo); end
        tick();
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (out_valid_lo !== 1'b1 || out_lo !== 3'b011 || out_last_lo !== 1'b0) begin bad++; $display("[TB] FAIL bp_stall cyc=%0d got v=%b o=%b l=%b want v=1 o=011 l=0", i, out_valid_lo, out_lo, out_last_lo); end
            tick(); #1;
        end
        out_ready = 1'b1;
        #1;
        total++; if (out_lo !== 3'b011 || out_last_lo !== 1'b0) begin bad++; $display("[TB] FAIL bp_release got o=%b l=%b want o=011 l=0", out_lo, out_last_lo); end
        tick(); #1;
        total++; if (out_valid_lo !== 1'b1 || out_lo !== 3'b000 || out_last_lo !== 1'b1) begin bad++; $display("[TB] FAIL bp_last got v=%b o=%b l=%b want v=1 o=000 l=1", out_valid_lo, out_lo, out_last_lo); end
        tick(); #1;
        total++; if (out_valid_lo !== 1'b0 || in_ready_lo !== 1'b1) begin bad++; $display("[TB] FAIL bp_done got v=%b r=%b want v=0 r=1", out_valid_lo, in_ready_lo); end
    endtask

    // Bit 7 alone, then bit 7 with bit 0.
    task automatic test_err();
        send_lo(8'b1000_0000);
        total++; if (err_lo !== 1'b1 || out_valid_lo !== 1'b0 || in_ready_lo !== 1'b1) begin bad++; $display("[TB] FAIL err_only got e=%b v=%b r=%b want e=1 v=0 r=1", err_lo, out_valid_lo, in_ready_lo); end
        tick(); #1;
        total++; if (err_lo !== 1'b0 || out_valid_lo !== 1'b0 || in_ready_lo !== 1'b1) begin bad++; $display("[TB] FAIL err_only_after got e=%b v=%b r=%b want e=0 v=0 r=1", err_lo, out_valid_lo, in_ready_lo); end
        send_lo(8'b1000_0001);
        total++; if (err_lo !== 1'b1 || out_valid_lo !== 1'b1 || out_lo !== 3'b001 || out_last_lo !== 1'b1) begin bad++; $display("[TB] FAIL err_b0 got e=%b v=%b o=%b l=%b want e=1 v=1 o=001 l=1", err_lo, out_valid_lo, out_lo, out_last_lo); end
        tick(); #1;
        total++; if (err_lo !== 1'b0 || out_valid_lo !== 1'b0 || in_ready_lo !== 1'b1) begin bad++; $display("[TB] FAIL err_b0_after got e=%b v=%b r=%b want e=0 v=0 r=1", err_lo, out_valid_lo, in_ready_lo); end
    endtask

    // Enable dropped for two cycles during the first code.
    task automatic test_enable();
        send_lo(8'b0001_1000);
        total++; if (out_valid_lo !== 1'b1 || out_lo !== 3'b100) begin bad++; $display("[TB] FAIL en_c0 got v=%b o=%b want v=1 o=100", out_valid_lo, out_lo); end
        en = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            total++; if (out_valid_lo !== 1'b0 || in_ready_lo !== 1'b0 || out_lo !== 3'b100) begin bad++; $display("[TB] FAIL en_low cyc=%0d got v=%b r=%b o=%b want v=0 r=0 o=100", i, out_valid_lo, in_ready_lo, out_lo); end
            tick(); #1;
        end
        en = 1'b1;
        #1;
        total++; if (out_valid_lo !== 1'b1 || out_lo !== 3'b100 || out_last_lo !== 1'b0) begin bad++; $display("[TB] FAIL en_resume got v=%b o=%b l=%b want v=1 o=100 l=0", out_valid_lo, out_lo, out_last_lo); end
        tick(); #1;
        total++; if (out_valid_lo !== 1'b1 || out_lo !== 3'b101 || out_last_lo !== 1'b1) begin bad++; $display("[TB] FAIL en_c1 got v=%b o=%b l=%b want v=1 o=101 l=1", out_valid_lo, out_lo, out_last_lo); end
        tick(); #1;
        total++; if (out_valid_lo !== 1'b0 || in_ready_lo !== 1'b1) begin bad++; $display("[TB] FAIL en_done got v=%b r=%b want v=0 r=1", out_valid_lo, in_ready_lo); end
    endtask

    // New vector held valid while the last code goes out: accepted one edge later.
    task automatic test_back_to_back();
        send_lo(8'b0000_0011);
        total++; if (out_lo !== 3'b001) begin bad++; $display("[TB] FAIL b2b_c0 got=%b want=001", out_lo); end
        tick(); #1;
        total++; if (out_lo !== 3'b010 || out_last_lo !== 1'b1) begin bad++; $display("[TB] FAIL b2b_c1 got o=%b l=%b want o=010 l=1", out_lo, out_last_lo); end
        in_vec      = 8'b0100_0000;
        in_valid_lo = 1'b1;
        tick(); #1;
        total++; if (in_ready_lo !== 1'b1 || out_valid_lo !== 1'b0) begin bad++; $display("[TB] FAIL b2b_gap got r=%b v=%b want r=1 v=0", in_ready_lo, out_valid_lo); end
        tick();
        in_valid_lo = 1'b0;
        #1;
        total++; if (out_valid_lo !== 1'b1 || out_lo !== 3'b000 || out_last_lo !== 1'b1) begin bad++; $display("[TB] FAIL b2b_next got v=%b o=%b l=%b want v=1 o=000 l=1", out_valid_lo, out_lo, out_last_lo); end
        tick(); #1;
        total++; if (out_valid_lo !== 1'b0) begin bad++; $display("[TB] FAIL b2b_done got v=%b want v=0", out_valid_lo); end
    endtask

    // Highest-first instance, with decoder loop-back.
    task automatic test_prio_high();
        total++; if (in_ready_hi !== 1'b1 || out_valid_hi !== 1'b0) begin bad++; $display("[TB] FAIL hi_idle got r=%b v=%b want r=1 v=0", in_ready_hi, out_valid_hi); end
        send_hi(8'b0010_0010);
        total++; if (out_valid_hi !== 1'b1 || out_hi !== 3'b111 || out_last_hi !== 1'b0) begin bad++; $display("[TB] FAIL hi_c0 got v=%b o=%b l=%b want v=1 o=111 l=0", out_valid_hi, out_hi, out_last_hi); end
        total++; if (decode(out_hi) !== 8'b0010_0000) begin bad++; $display("[TB] FAIL hi_loop0 got=%b want=00100000", decode(out_hi)); end
        tick(); #1;
        total++; if (out_valid_hi !== 1'b1 || out_hi !== 3'b010 || out_last_hi !== 1'b1) begin bad++; $display("[TB] FAIL hi_c1 got v=%b o=%b l=%b want v=1 o=010 l=1", out_valid_hi, out_hi, out_last_hi); end
        total++; if (decode(out_hi) !== 8'b0000_0010) begin bad++; $display("[TB] FAIL hi_loop1 got=%b want=00000010", decode(out_hi)); end
        tick(); #1;
        total++; if (out_valid_hi !== 1'b0 || in_ready_hi !== 1'b1) begin bad++; $display("[TB] FAIL hi_done got v=%b r=%b want v=0 r=1", out_valid_hi, in_ready_hi); end
    endtask

    // Test sequence.
    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        en          = 1'b1;
        in_vec      = 8'h00;
        in_valid_lo = 1'b0;
        in_valid_hi = 1'b0;
        out_ready   = 1'b1;
        #3;
        $display("[TB] starting");
        test_reset();
        test_basic();
        test_backpressure();
        test_err();
        test_enable();
        test_back_to_back();
        test_prio_high();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
